// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: data word type,
// ALU select encodings and flag bit positions.
package alu_pkg;

  localparam int DW = 16;
  typedef logic [DW-1:0] word_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_B = 0;

  function automatic logic is_zero(input word_t v);
    return (v == 16'd0);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x 16 register file: two asynchronous read ports, a writeback port and
// an external load port. The writeback port wins on an address collision.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 8,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [15:0]   ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [15:0]   rb_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [15:0]   wb_data,
  input  logic          ext_en,
  input  logic [AW-1:0] ext_addr,
  input  logic [15:0]   ext_data
);

  word_t mem_r [NREG];

  // Read ports are plain array lookups.
  always_comb begin
    ra_data = mem_r[ra_addr];
    rb_data = mem_r[rb_addr];
  end

  // Per-entry write with writeback taking priority over external load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          mem_r[i] <= wb_data;
        end else if (ext_en && (ext_addr == AW'(i))) begin
          mem_r[i] <= ext_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Operand fetch, issue and writeback around an external 16-bit ALU:
// one EX register stage, forwarding from the in-flight result, streamed output.
module alu_issue
  import alu_pkg::*;
#(
  parameter int NREG = 8,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_rd,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  output logic [15:0]   alu_x,
  output logic [15:0]   alu_y,
  output logic [2:0]    alu_sel,
  input  logic [15:0]   alu_res,
  input  logic          alu_carry,
  input  logic          alu_borrow,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data,
  output logic [AW-1:0] res_rd,
  output logic [2:0]    flags
);

  logic          ex_valid_r;
  word_t         ex_x_r;
  word_t         ex_y_r;
  logic [2:0]    ex_sel_r;
  logic [AW-1:0] ex_rd_r;

  logic          res_valid_r;
  word_t         res_data_r;
  logic [AW-1:0] res_rd_r;
  logic [2:0]    flags_r;

  word_t rf_a_s;
  word_t rf_b_s;
  word_t op_x_s;
  word_t op_y_s;
  logic  wb_go_s;
  logic  accept_s;

  alu_regfile #(.NREG(NREG)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (in_rs1),
    .ra_data  (rf_a_s),
    .rb_addr  (in_rs2),
    .rb_data  (rf_b_s),
    .wb_en    (wb_go_s),
    .wb_addr  (ex_rd_r),
    .wb_data  (alu_res),
    .ext_en   (wr_en),
    .ext_addr (wr_addr),
    .ext_data (wr_data)
  );

  // Handshake and operand selection; the result being written this cycle
  // bypasses the regfile so a dependent instruction can issue without a bubble.
  always_comb begin
    wb_go_s  = ex_valid_r && (!res_valid_r || res_ready);
    in_ready = !rst && (!ex_valid_r || wb_go_s);
    accept_s = in_valid && in_ready;
    if (wb_go_s && (in_rs1 == ex_rd_r)) begin
      op_x_s = alu_res;
    end else begin
      op_x_s = rf_a_s;
    end
    if (wb_go_s && (in_rs2 == ex_rd_r)) begin
      op_y_s = alu_res;
    end else begin
      op_y_s = rf_b_s;
    end
  end

  // EX stage: operands persist after the slot empties so the ALU inputs stay quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
      ex_x_r     <= 16'd0;
      ex_y_r     <= 16'd0;
      ex_sel_r   <= 3'd0;
      ex_rd_r    <= '0;
    end else begin
      if (accept_s) begin
        ex_valid_r <= 1'b1;
        ex_x_r     <= op_x_s;
        ex_y_r     <= op_y_s;
        ex_sel_r   <= in_op;
        ex_rd_r    <= in_rd;
      end else if (wb_go_s) begin
        ex_valid_r <= 1'b0;
      end
    end
  end

  // WB stage: capture result and flags, or retire the held result once consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_data_r  <= 16'd0;
      res_rd_r    <= '0;
      flags_r     <= 3'd0;
    end else begin
      if (wb_go_s) begin
        res_valid_r     <= 1'b1;
        res_data_r      <= alu_res;
        res_rd_r        <= ex_rd_r;
        flags_r[FLAG_Z] <= is_zero(alu_res);
        flags_r[FLAG_C] <= alu_carry;
        flags_r[FLAG_B] <= alu_borrow;
      end else if (res_valid_r && res_ready) begin
        res_valid_r <= 1'b0;
      end
    end
  end

  assign alu_x     = ex_x_r;
  assign alu_y     = ex_y_r;
  assign alu_sel   = ex_sel_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_rd    = res_rd_r;
  assign flags     = flags_r;

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-fetch, issue and writeback stage wrapped around the 16-bit combinational ALU. It holds an NREG x 16-bit register file and accepts register-to-register instructions over a valid/ready handshake. It drives the ALU's X/Y/sel inputs from a registered execute stage and writes the ALU result and flags back one cycle later. Results are also streamed out on a valid/ready port for the downstream consumer.

## Interface
- NREG, 8: register-file depth; power of two, 2..32. AW = $clog2(NREG).
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid && in_ready
- in_op  in  3  ALU select code, 000..111, same encoding as ALU sel
- in_rd, in_rs1, in_rs2  in  AW each  destination, source X, source Y
- wr_en  in  1  external register load
- wr_addr  in  AW  load address
- wr_data  in  16  load data
- alu_x, alu_y  out  16  to ALU X, Y
- alu_sel  out  3  to ALU sel
- alu_res  in  16  from ALU alu_out
- alu_carry, alu_borrow  in  1  from ALU carry_out, borrow_out
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts
- res_data  out  16  written-back value
- res_rd  out  AW  destination of res_data
- flags  out  3  {zero, carry, borrow} of last writeback

## Operation
- Pipeline: ISSUE (combinational regfile read) -> EX register (ex_valid, x, y, sel, rd) -> WB (regfile write + result register).
- wb_go = ex_valid && (!res_valid || res_ready).
- in_ready = !rst && (!ex_valid || wb_go).
- On accept, EX loads operands: x = rf[rs1], y = rf[rs2], sel = in_op, rd = in_rd.
- Forwarding: if wb_go and rs1 (or rs2) == ex.rd, the operand is taken from alu_res, not rf. This also applies when rs1 == rs2 == ex.rd.
- alu_x/alu_y/alu_sel come straight from EX registers. When ex_valid = 0 they hold their last values; the ALU output is ignored.
- On wb_go:
  - rf[ex.rd] <= alu_res
  - res_data <= alu_res, res_rd <= ex.rd, res_valid <= 1
  - flags <= {alu_res == 0, alu_carry, alu_borrow}
  - ex_valid <= accept this cycle
- If there is no wb_go and res_ready && res_valid, res_valid <= 0.
- Stall: with res_valid = 1 and res_ready = 0, EX holds, in_ready = 0, and no regfile write from WB occurs.
- External write: rf[wr_addr] <= wr_data on any cycle with wr_en.
  - Same address as a WB write in the same cycle: WB wins, external data dropped.
  - Different address: both writes occur.
  - External writes are not forwarded. An instruction accepted in the same cycle reads the old value.
- No hazard beyond one EX entry exists. The regfile is written only at WB, and forwarding covers the single in-flight instruction.

## Timing
- Reset (async, while rst = 1): rf all 0, ex_valid = 0, res_valid = 0, res_data = 0, res_rd = 0, flags = 0, alu_x = alu_y = 0, alu_sel = 0, in_ready = 0.
- Latency: instruction accepted at edge E0 -> alu_* valid after E0 -> regfile written and res_valid = 1 after E1, provided res_ready was high or the slot empty.
- Throughput: one instruction per cycle while res_ready = 1.
- Arithmetic: all values 16-bit unsigned. Carry and borrow are taken verbatim from the ALU; no local recomputation.
- Reset mid-operation discards the EX entry and the pending result. No partial regfile write occurs.

## Structure
- Package alu_pkg holds:
  - localparams for op codes: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101, OP_SHL=110, OP_SHR=111
  - flag bit indices: FLAG_Z=2, FLAG_C=1, FLAG_B=0
- One sub-module: alu_regfile, NREG x 16 with two asynchronous read ports and two synchronous write ports. The priority rule (WB port wins) is implemented inside it.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Load r1 = 0xFFFF, r2 = 0x0001 via wr_en; issue ADD r3, r1, r2 -> after E1: res_data = 0x0000, res_rd = 3, flags = 3'b110, rf[3] = 0.
- Load r1 = 0x0003, r2 = 0x0005; issue SUB r4, r1, r2 -> res_data = 0xFFFE, flags = 3'b001.
- Back-to-back forwarding: with r1 = 1, r2 = 2, issue ADD r3,r1,r2 then ADD r5,r3,r3 on consecutive cycles -> res_data 3 then 6; no bubble.
- Backpressure: hold res_ready = 0 with two instructions issued -> in_ready drops after the first; res_data stays stable. Release res_ready -> second result follows one cycle later.
- Write conflict: WB to r6 and wr_en to r6 with 0x1234 in the same cycle -> rf[6] = ALU result. A separate-address write in the same cycle lands.
- Assert rst while ex_valid = 1 -> all outputs 0 immediately, rf cleared, and no res_valid pulse after release.
